// File: rtl/frame_scan_controller.sv
// frame_scan_controller: raster-scan pixel sequencer tagging pixels with col/row, window/row/frame flags and frame count
module frame_scan_controller #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int FRAME_COLS    = 640,
  parameter int FRAME_ROWS    = 480,
  parameter int WINDOW_SIZE   = 24,
  parameter int COL_W         = 10,
  parameter int ROW_W         = 9
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_detect_busy,
  input  logic [DATA_WIDTH_12-1:0] i_pixel,
  input  logic                     i_pixel_valid,
  output logic                     o_pixel_request,
  output logic [DATA_WIDTH_12-1:0] o_pixel,
  output logic                     o_pixel_valid,
  output logic [COL_W-1:0]         o_col,
  output logic [ROW_W-1:0]         o_row,
  output logic                     o_window_ready,
  output logic                     o_end_row,
  output logic                     o_end_frame,
  output logic                     o_frame_done,
  output logic [15:0]              o_frame_count,
  output logic                     o_busy
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_ROWS - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(WINDOW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(WINDOW_SIZE - 1);
  state_t state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic accept, last, start_ok, done_ok;
  assign o_pixel_request = (state == FETCH) && !i_detect_busy && !i_abort;
  assign accept          = o_pixel_request && i_pixel_valid;
  assign last            = (col == COL_LAST) && (row == ROW_LAST);
  // a start coinciding with the done pulse is dropped so every frame needs a fresh start in IDLE
  assign start_ok        = i_start && !o_frame_done;
  assign done_ok         = (state == DONE) && !i_abort;
  assign o_busy          = state != IDLE;
  assign o_window_ready  = o_pixel_valid && (o_col >= COL_WIN) && (o_row >= ROW_WIN);
  assign o_end_row       = o_pixel_valid && (o_col == COL_LAST);
  assign o_end_frame     = o_end_row && (o_row == ROW_LAST);
  always_comb begin
    state_nxt = IDLE;
    if (!i_abort)
      state_nxt = (state == IDLE)  ? (start_ok ? FETCH : IDLE) :
                  (state == FETCH) ? ((accept && last) ? DONE : FETCH) : IDLE;
  end
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_col         <= '0;
      o_row         <= '0;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
    end else begin
      state         <= state_nxt;
      o_pixel_valid <= accept;
      o_frame_done  <= done_ok;
      if (done_ok) o_frame_count <= o_frame_count + 16'd1;
      if (state == IDLE && start_ok && !i_abort) begin
        col <= '0;
        row <= '0;
      end
      if (accept) begin
        o_pixel <= i_pixel;
        o_col   <= col;
        o_row   <= row;
        if (!last) begin
          col <= (col == COL_LAST) ? '0 : col + 1'b1;
          row <= (col == COL_LAST) ? row + 1'b1 : row;
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_scan_controller.sv
// tb_frame_scan_controller: directed + randomized checks against a pixel-index reference model
module tb_frame_scan_controller;
  localparam int C = 8, R = 4, W = 3, CW = 3, RW = 2;
  logic clk_fpga = 0, reset_fpga = 0;
  logic i_start = 0, i_abort = 0, i_detect_busy = 0, i_pixel_valid = 0;
  logic [11:0] i_pixel = 0;
  logic o_pixel_request, o_pixel_valid, o_window_ready, o_end_row, o_end_frame, o_frame_done, o_busy;
  logic [11:0] o_pixel;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;
  logic [15:0] o_frame_count;
  int cmp = 0, bad = 0;
  int n = 0;
  bit fetching = 0, in_done = 0, fd_now = 0;
  logic [15:0] frames = 0;

  frame_scan_controller #(.DATA_WIDTH_12(12), .FRAME_COLS(C), .FRAME_ROWS(R), .WINDOW_SIZE(W),
    .COL_W(CW), .ROW_W(RW)) dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_start(i_start), .i_abort(i_abort),
    .i_detect_busy(i_detect_busy), .i_pixel(i_pixel), .i_pixel_valid(i_pixel_valid),
    .o_pixel_request(o_pixel_request), .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid),
    .o_col(o_col), .o_row(o_row), .o_window_ready(o_window_ready), .o_end_row(o_end_row),
    .o_end_frame(o_end_frame), .o_frame_done(o_frame_done), .o_frame_count(o_frame_count),
    .o_busy(o_busy));

  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock of stimulus; the model tracks the frame as "pixel index n" and derives position arithmetically
  task automatic cycle(input bit s, input bit v, input bit b, input bit a, input logic [11:0] px);
    bit acc, was_done, idle;
    int k;
    i_start = s; i_pixel_valid = v; i_detect_busy = b; i_abort = a; i_pixel = px;
    #1;
    chk("request", {31'd0, o_pixel_request}, {31'd0, fetching && !b && !a});
    acc = fetching && !b && !a && v;
    k = n;
    was_done = in_done && !a;
    idle = !fetching && !in_done;
    @(posedge clk_fpga); #1;
    in_done = 0;
    if (acc) begin
      n++;
      if (n == C * R) begin fetching = 0; in_done = 1; end
    end
    if (a) fetching = 0;
    else if (s && idle && !fd_now) begin fetching = 1; n = 0; end
    fd_now = was_done;
    if (was_done) frames++;
    chk("pixel_valid", {31'd0, o_pixel_valid}, {31'd0, acc});
    if (acc) begin
      chk("pixel", {20'd0, o_pixel}, {20'd0, px});
      chk("col", {29'd0, o_col}, k % C);
      chk("row", {30'd0, o_row}, k / C);
    end
    chk("window_ready", {31'd0, o_window_ready}, {31'd0, acc && (k % C) >= W - 1 && (k / C) >= W - 1});
    chk("end_row", {31'd0, o_end_row}, {31'd0, acc && (k % C) == C - 1});
    chk("end_frame", {31'd0, o_end_frame}, {31'd0, acc && k == C * R - 1});
    chk("frame_done", {31'd0, o_frame_done}, {31'd0, was_done});
    chk("frame_count", {16'd0, o_frame_count}, {16'd0, frames});
    chk("busy", {31'd0, o_busy}, {31'd0, fetching || in_done});
  endtask

  task automatic run_frame(input int busy_at, input int abort_at);
    int busy_left = 5;
    cycle(1, 0, 0, 0, 0);
    for (int g = 0; g < 200 && (fetching || in_done); g++) begin
      if (n == abort_at && fetching) cycle(0, 1, 0, 1, 12'(n));
      else if (n == busy_at && busy_left > 0) begin cycle(0, 1, 1, 0, 12'(n)); busy_left--; end
      else cycle(0, 1, 0, 0, 12'(n));
    end
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("idle_after_frame", {31'd0, o_busy}, 0);
  endtask

  initial begin
    #2;
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_request", {31'd0, o_pixel_request}, 0);
    chk("rst_pixel", {20'd0, o_pixel}, 0);
    chk("rst_count", {16'd0, o_frame_count}, 0);
    @(posedge clk_fpga); #1;
    reset_fpga = 1;
    cycle(1, 0, 0, 0, 0);
    while (n < 5) cycle(0, 1, 0, 0, 12'(n) + 12'h100);
    reset_fpga = 0;
    #1;
    chk("midrst_busy", {31'd0, o_busy}, 0);
    chk("midrst_request", {31'd0, o_pixel_request}, 0);
    chk("midrst_valid", {31'd0, o_pixel_valid}, 0);
    chk("midrst_pixel", {20'd0, o_pixel}, 0);
    chk("midrst_col", {29'd0, o_col}, 0);
    fetching = 0; in_done = 0; fd_now = 0; n = 0; frames = 0;
    @(posedge clk_fpga); #1;
    reset_fpga = 1;
    run_frame(-1, -1);
    chk("count_after_frame1", {16'd0, o_frame_count}, 1);
    run_frame(10, -1);
    chk("count_after_busy_frame", {16'd0, o_frame_count}, 2);
    run_frame(-1, 20);
    chk("count_after_abort", {16'd0, o_frame_count}, 2);
    cycle(1, 0, 0, 0, 0);
    for (int g = 0; g < 1000 && (fetching || in_done); g++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 0,
            12'($urandom));
    cycle(1, 0, 0, 0, 0);
    chk("start_on_done_ignored", {31'd0, o_busy}, 0);
    cycle(0, 0, 0, 0, 0);
    chk("count_after_random", {16'd0, o_frame_count}, 3);
    force dut.o_frame_count = 16'hFFFF;
    #1;
    release dut.o_frame_count;
    frames = 16'hFFFF;
    run_frame(-1, -1);
    chk("count_wrap", {16'd0, o_frame_count}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
